// File: rtl/uart_img_streamer.sv
// Streams a byte image from a sync-read memory into a UART TX port, with optional header framing.
// Define UART_IMG_STREAMER_CSUM_EN to append a two's-complement checksum trailer after the payload.
module uart_img_streamer #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned LEN_W    = 16,
   parameter int unsigned HDR_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  len,
   input  logic              abort,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rd_data,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_busy,
   output logic              busy,
   output logic [LEN_W-1:0]  byte_cnt,
   output logic              done,
   output logic              aborted
);

   typedef enum logic [2:0] {
      StIdle, StHdr, StFetch, StWait, StSend, StGap, StCsum, StDone
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        byte_q, byte_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic [1:0]        hdr_idx_q, hdr_idx_d;
   logic              payload_q, payload_d;
   logic              tx_valid_q, tx_valid_d;
   logic              done_q, done_d;
   logic              aborted_q, aborted_d;
   logic [15:0]       len16;
   logic [7:0]        hdr_byte;
`ifdef UART_IMG_STREAMER_CSUM_EN
   logic [7:0]        sum_q, sum_d;
   logic              csum_sent_q, csum_sent_d;
`endif

   assign len16 = 16'(len_q);

   always_comb begin
      case (hdr_idx_q)
         2'd0:    hdr_byte = 8'hA5;
         2'd1:    hdr_byte = len16[7:0];
         default: hdr_byte = len16[15:8];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      byte_d     = byte_q;
      tx_data_d  = tx_data_q;
      hdr_idx_d  = hdr_idx_q;
      payload_d  = payload_q;
      tx_valid_d = 1'b0;
      done_d     = 1'b0;
      aborted_d  = 1'b0;
      mem_rd_en  = 1'b0;
      mem_addr   = '0;
`ifdef UART_IMG_STREAMER_CSUM_EN
      sum_d       = sum_q;
      csum_sent_d = csum_sent_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               len_d     = len;
               addr_d    = start_addr;
               cnt_d     = '0;
               hdr_idx_d = '0;
`ifdef UART_IMG_STREAMER_CSUM_EN
               sum_d       = '0;
               csum_sent_d = 1'b0;
`endif
               if (HDR_MODE != 0) begin
                  state_d = StHdr;
               end else if (len == '0) begin
`ifdef UART_IMG_STREAMER_CSUM_EN
                  state_d = StCsum;
`else
                  state_d = StDone;
`endif
               end else begin
                  state_d = StFetch;
               end
            end
         end
         StHdr: begin
            byte_d    = hdr_byte;
            hdr_idx_d = hdr_idx_q + 2'd1;
            payload_d = 1'b0;
            state_d   = StSend;
         end
         StFetch: begin
            mem_rd_en = 1'b1;
            mem_addr  = addr_q;
            state_d   = StWait;
         end
         StWait: begin
            byte_d    = mem_rd_data;
            payload_d = 1'b1;
            state_d   = StSend;
         end
         StSend: begin
            if (!tx_busy) begin
               tx_valid_d = 1'b1;
               tx_data_d  = byte_q;
               if (payload_q) begin
                  cnt_d  = cnt_q + 1'b1;
                  addr_d = addr_q + 1'b1;
`ifdef UART_IMG_STREAMER_CSUM_EN
                  sum_d  = sum_q + byte_q;
`endif
               end
               state_d = StGap;
            end
         end
         StGap: begin
            if ((HDR_MODE != 0) && (hdr_idx_q < 2'd3)) begin
               state_d = StHdr;
            end else if (cnt_q < len_q) begin
               state_d = StFetch;
`ifdef UART_IMG_STREAMER_CSUM_EN
            end else if (!csum_sent_q) begin
               state_d = StCsum;
`endif
            end else begin
               state_d = StDone;
            end
         end
         StCsum: begin
`ifdef UART_IMG_STREAMER_CSUM_EN
            byte_d      = 8'd0 - sum_q;
            csum_sent_d = 1'b1;
`endif
            payload_d = 1'b0;
            state_d   = StSend;
         end
         StDone: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Abort wins over any pending send; a strobe already on the wire ends by itself.
      if (abort && (state_q != StIdle)) begin
         state_d    = StIdle;
         aborted_d  = 1'b1;
         done_d     = 1'b0;
         tx_valid_d = 1'b0;
         tx_data_d  = tx_data_q;
         cnt_d      = cnt_q;
         addr_d     = addr_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         byte_q     <= '0;
         tx_data_q  <= '0;
         hdr_idx_q  <= '0;
         payload_q  <= 1'b0;
         tx_valid_q <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
`ifdef UART_IMG_STREAMER_CSUM_EN
         sum_q       <= '0;
         csum_sent_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         byte_q     <= byte_d;
         tx_data_q  <= tx_data_d;
         hdr_idx_q  <= hdr_idx_d;
         payload_q  <= payload_d;
         tx_valid_q <= tx_valid_d;
         done_q     <= done_d;
         aborted_q  <= aborted_d;
`ifdef UART_IMG_STREAMER_CSUM_EN
         sum_q       <= sum_d;
         csum_sent_q <= csum_sent_d;
`endif
      end
   end

   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
   assign busy     = (state_q != StIdle);
   assign byte_cnt = cnt_q;
   assign done     = done_q;
   assign aborted  = aborted_q;

endmodule

// File: doc/uart_img_streamer.md
# uart_img_streamer

Synthesizable byte streamer that reads an image from a synchronous-read byte memory and pushes it, one byte at a time, into a UART transmitter with a `tx_busy` handshake. It is the parametrised, in-fabric successor of the bench-side upgrade feeder. It adds:
- a configurable start address and length
- an optional framing header
- an optional two's-complement checksum trailer
- abort support

It sits between a boot/upgrade ROM or RAM and the `uart` TX port, for example a debug or host-side loader.

## Interface
- `ADDR_W`, 16, memory address width; the address wraps modulo 2^ADDR_W.
- `LEN_W`, 16, length width; must be 16 when `HDR_MODE`=1.
- `HDR_MODE`, 0, selects the framing.
  - 0: raw payload only.
  - 1: header 0xA5, len[7:0], len[15:8] precedes the payload.

Ports (the clock is `clk`; the reset is `rst`, asynchronous and active-high):
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `start_addr`  in  ADDR_W  first byte address; sampled with `start`.
- `len`  in  LEN_W  payload byte count; sampled with `start`.
- `abort`  in  1  cancels an active transfer.
- `mem_rd_en`  out  1  memory read strobe.
- `mem_addr`  out  ADDR_W  memory read address.
- `mem_rd_data`  in  8  read data, valid the cycle after `mem_rd_en`.
- `tx_valid`  out  1  one-cycle byte strobe to the UART.
- `tx_data`  out  8  byte to transmit; valid while `tx_valid`=1.
- `tx_busy`  in  1  UART busy flag.
- `busy`  out  1  high in every state except IDLE.
- `byte_cnt`  out  LEN_W  payload bytes issued so far.
- `done`  out  1  one-cycle pulse when a transfer completes.
- `aborted`  out  1  one-cycle pulse when a transfer is cancelled.

## Operation
- States: IDLE, HDR, FETCH, WAIT, SEND, GAP, CSUM, DONE.
- IDLE:
  - `start`=1 latches `len`, loads addr=`start_addr`, and clears cnt, sum and hdr_idx.
  - Next state is HDR if `HDR_MODE`=1, otherwise FETCH.
  - In raw mode, a `start` with `len`=0 goes directly to DONE.
- HDR: loads header byte [hdr_idx] into the byte register, increments hdr_idx, then goes to SEND.
- FETCH: `mem_rd_en`=1 and `mem_addr`=addr (both combinational from state), then WAIT.
- WAIT: captures `mem_rd_data` into the byte register, then SEND.
- SEND:
  - Holds while `tx_busy`=1.
  - With `tx_busy`=0, registers `tx_valid`=1 and `tx_data`=byte, then goes to GAP.
  - For payload bytes only, also does cnt+1, addr+1 and sum+=byte (mod 256).
- GAP: one cycle with `tx_valid` high, giving the UART time to raise `tx_busy`. The decision at its end, in priority order:
  1. hdr_idx<3 in HDR_MODE → HDR.
  2. cnt<len → FETCH.
  3. Checksum enabled and not yet sent → CSUM.
  4. Otherwise → DONE.
- CSUM: loads (−sum) mod 256 into the byte register, then SEND.
- DONE: `done`=1 for one cycle, then IDLE.
- `abort`=1 in any non-IDLE state:
  - Next state is IDLE and `aborted`=1 for one cycle.
  - A `tx_valid` already asserted completes its single cycle.
  - `abort` in IDLE is ignored. `start` together with `abort` in IDLE starts the transfer.
- `start` while `busy`=1 is ignored.
- `byte_cnt` holds its final value after DONE or abort until the next `start`.

## Timing
- Reset values of all outputs are 0: `tx_valid`, `tx_data`, `mem_rd_en`, `mem_addr`, `busy`, `byte_cnt`, `done`, `aborted`. State is IDLE.
- With `start` sampled at edge E0 in raw mode, FETCH occupies cycle 1 and WAIT cycle 2. The first `tx_valid` is high in cycle 4 if `tx_busy`=0.
- Minimum byte spacing is 4 cycles (FETCH, WAIT, SEND, GAP). The actual spacing is UART-limited.
- `tx_valid` is never high for two consecutive cycles.
- `done` follows the last `tx_valid` by 2 cycles (GAP then DONE).
- Address wrap: with `start_addr`=0xFFFF and `len`=2, the reads are 0xFFFF and then 0x0000.

## Configuration
- Macro: `UART_IMG_STREAMER_CSUM_EN`.
- Defined: after the payload, one trailer byte (−Σpayload) mod 256 is sent, so that payload+trailer sums to 0 mod 256. The header bytes are excluded from the sum. The trailer is not counted in `byte_cnt`. In raw mode with `len`=0, the transfer goes HDR/CSUM-only: a single trailer 0x00 is sent.
- Undefined: the CSUM state and the sum register are absent, and the transfer ends after the payload.

## Test plan
- Raw mode, memory[0x10..0x13]=11 22 33 44, `start` with `start_addr`=0x10 and `len`=4, UART model busy for 20 cycles per byte → `tx_data` 11,22,33,44; `byte_cnt`=4; one `done` pulse.
- `HDR_MODE`=1, `len`=3 → A5, 03, 00, then 3 payload bytes; with CSUM_EN defined and payload 01 02 03 the trailer is FA.
- `start_addr`=0xFFFE, `len`=3 → reads 0xFFFE, 0xFFFF, 0x0000.
- `abort` asserted during the 2nd byte's SEND with `len`=8 → no further `tx_valid`; `aborted` pulses once; `done` stays 0; `byte_cnt`=1.
- `tx_busy` held high for 100 cycles at SEND → `tx_valid` stays 0 and then fires exactly once on release; `start` pulsed while busy is ignored.
- `rst` asserted mid-transfer → all outputs are 0 immediately; a new `start` after reset streams from `start_addr` correctly.
